// File: rtl/reg_file_pkg.sv
// Shared types for the register-file write front end.
package reg_file_pkg;

   typedef enum logic [1:0] {
      WR_LOW,
      WR_HIGH,
      WR_FULL
   } wr_state_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_writer.sv
// reg_file_writer: packs pairs of DATA_WIDTH items into {upper, lower} words
// and writes them to sequential register-file addresses.
// Optional build macro REG_FILE_WRITER_WRAP_EN: instead of stalling when all
// entries are written, the pointer wraps and overwrites the oldest entries.
module reg_file_writer
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   input  logic                    clear,
   output logic                    w_en,
   output logic [ADDR_WIDTH-1:0]   w_addr,
   output logic [2*DATA_WIDTH-1:0] w_data,
   output logic [ADDR_WIDTH:0]     count,
   output logic                    full
);

   localparam int unsigned          DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]  COUNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

   wr_state_t               state_q, state_d;
   logic [DATA_WIDTH-1:0]   lower_q, lower_d;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic                    w_en_q, w_en_d;
   logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
   logic [2*DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [ADDR_WIDTH:0]     count_q, count_d;
   logic                    full_q, full_d;
   logic                    transfer;
   logic [DATA_WIDTH-1:0]   upper;

   // Ready whenever not in reset, not clearing, and not stalled on a full file.
   always_comb begin
      in_ready = reset_n && !clear && (state_q != WR_FULL);
      transfer = in_valid && in_ready;
      upper    = transfer ? in_data : '0;
   end

   // Next-state, packing, pointer and count logic; clear overrides everything.
   always_comb begin
      state_d  = state_q;
      lower_d  = lower_q;
      wr_ptr_d = wr_ptr_q;
      w_en_d   = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      count_d  = count_q;
      full_d   = full_q;

      if (clear) begin
         state_d  = WR_LOW;
         lower_d  = '0;
         wr_ptr_d = '0;
         w_addr_d = '0;
         count_d  = '0;
         full_d   = 1'b0;
      end else begin
         unique case (state_q)
            WR_LOW: begin
               if (transfer) begin
                  lower_d = in_data;
                  state_d = WR_HIGH;
               end
            end
            WR_HIGH: begin
               // A transfer completes the word; flush alone pads the upper half with zero.
               if (transfer || flush) begin
                  w_en_d   = 1'b1;
                  w_addr_d = wr_ptr_q;
                  w_data_d = {upper, lower_q};
                  wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                  state_d  = WR_LOW;
`ifdef REG_FILE_WRITER_WRAP_EN
                  count_d  = (count_q == COUNT_MAX) ? COUNT_MAX : count_q + (ADDR_WIDTH + 1)'(1);
                  full_d   = full_q || (count_d == COUNT_MAX);
`else
                  count_d  = count_q + (ADDR_WIDTH + 1)'(1);
                  if (wr_ptr_q == PTR_LAST) begin
                     full_d  = 1'b1;
                     state_d = WR_FULL;
                  end
`endif
               end
            end
            WR_FULL: begin
               state_d = WR_FULL;
            end
            default: begin
               state_d = WR_LOW;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= WR_LOW;
         lower_q  <= '0;
         wr_ptr_q <= '0;
         w_en_q   <= 1'b0;
         w_addr_q <= '0;
         w_data_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lower_q  <= lower_d;
         wr_ptr_q <= wr_ptr_d;
         w_en_q   <= w_en_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   assign w_en   = w_en_q;
   assign w_addr = w_addr_q;
   assign w_data = w_data_q;
   assign count  = count_q;
   assign full   = full_q;

endmodule : reg_file_writer
